mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and access sequencer for the shared data memory (`ext_mem`). Port 0 serves the core load/store unit and port 1 serves a secondary master (loader or DMA). Each accepted transaction is issued to the memory with the two-cycle read protocol the memory requires (request and address held across the data cycle). Every transaction returns a registered response pulse, and out-of-range words are rejected without touching memory.

## Interface
- `MEM_WORDS`, 4096: number of 32-bit words in memory; word index is `addr[31:2]`.
- `ERR_DATA`, 32'hdead_beef: read data returned on an out-of-range access.
- `clk_i`  in  1: clock, all state on rising edge.
- `rst_i`  in  1: reset; one clock; reset is asynchronous and active-high.
- `mN_req_i`  in  1: request from port N (N=0,1); held with fields stable until `mN_gnt_o`.
- `mN_we_i`  in  1: 1 = write, 0 = read.
- `mN_be_i`  in  4: byte enables, for writes only.
- `mN_addr_i`  in  32: byte address.
- `mN_wdata_i`  in  32: write data.
- `mN_gnt_o`  out  1: request accepted this cycle (combinational, IDLE only).
- `mN_rsp_o`  out  1: one-cycle response pulse for the port's transaction.
- `mN_err_o`  out  1: valid with `rsp`; 1 = address out of range.
- `mN_rdata_o`  out  32: response data; both ports drive the shared register; valid at `mN_rsp_o`.
- `mem_req_o`, `mem_we_o`  out  1: to `ext_mem`.
- `mem_be_o`  out  4: byte enables to `ext_mem`.
- `mem_addr_o`, `mem_wdata_o`  out  32: address and write data to `ext_mem`.
- `mem_rdata_i`  in  32: memory read data, valid in the second held read cycle.
- `mem_ready_i`  in  1: memory can accept or finish the current cycle.

## Operation
- **States:** IDLE, WR, RD1, RD2, ERR.
- **IDLE** (`mem_req_o`=0):
  - If any `req` is high, pick a winner and pulse its `gnt`.
  - Latch we/be/addr/wdata and the owner id.
  - Go to ERR if `addr[31:2] >= MEM_WORDS`, else to WR if `we`, else to RD1.
- **Arbitration** is round-robin with a 1-bit priority pointer; reset value 0 (port 0 first).
  - With a single requester, that port wins.
  - With both requesting, the pointer port wins.
  - After any grant, the pointer moves to the other port.
- **WR:** drives `mem_req_o`=1, `mem_we_o`=1 and the latched fields. When `mem_ready_i`=1, go to IDLE and set the owner's rsp (err=0). `rdata` is unchanged.
- **RD1:** drives `mem_req_o`=1, `mem_we_o`=0 and the latched address. When `mem_ready_i`=1, go to RD2.
- **RD2:** keeps the same outputs as RD1. When `mem_ready_i`=1, capture `mem_rdata_i` into `rdata_q`, go to IDLE and set rsp.
- **ERR:** no memory access. In one cycle, load `rdata_q`=`ERR_DATA`, set rsp with err=1 and go to IDLE.
- **Idle memory outputs:** when not in WR/RD1/RD2, `mem_we_o`/`mem_be_o`/`mem_addr_o`/`mem_wdata_o` drive 0.
- **Ignored requests:** requests arriving outside IDLE are not granted; the master keeps `req` asserted.
- **Low address bits:** `addr[1:0]` is passed through unchanged; alignment is the master's responsibility.

## Timing
- **Reset values:** all outputs 0, `rdata_q`=0, state IDLE, pointer 0.
- **Reset mid-transaction:** `mem_req_o` drops asynchronously and the transaction is dropped with no rsp.
- **Grant latency:** `gnt` is in cycle c0, the IDLE cycle.
- **Write latency:**
  - `mem_req_o` in c1.
  - `rsp` registered in c2.
  - Each cycle of `mem_ready_i`=0 adds one cycle.
- **Read latency:**
  - `mem_req_o` in c1–c2 with a stable address.
  - `rdata` sampled at the end of c2.
  - `rsp` and `rdata` in c3.
  - Each stall cycle in RD1 or RD2 adds one cycle.
- **Error latency:** ERR in c1, `rsp` in c2, `mem_req_o` never asserted.
- **Back-to-back:** the FSM is in IDLE during the rsp cycle, so a new grant may coincide with the previous rsp. Peak throughput is one read per 3 cycles or one write per 2 cycles.
- **Response stability:** `rsp` and `err` last exactly one cycle. `rdata_q` holds until the next read or error response.

## Structure
- **`mem_arb_pkg`** holds:
  - the state enum `arb_state_t` (IDLE, WR, RD1, RD2, ERR);
  - the default `MEM_WORDS`;
  - the `ERR_DATA` constant;
  - the port-id type (1 bit).
- **`rr_arb2` sub-module:** a two-requester round-robin grant with the priority pointer.
  - Inputs: `req[1:0]`, `advance`.
  - Output: one-hot `gnt[1:0]`.
  - The top-level FSM, request latch and response registers live in `mem_arbiter`.

## Test plan
- **Reset:** assert `rst_i` mid-cycle → all outputs 0 immediately; after release, the first simultaneous request goes to port 0.
- **Port 0 read:** addr 0x10 with memory word 4 = 0x1234_5678 → `m0_gnt` c0; `mem_req_o`=1, `mem_addr_o`=0x10 in c1–c2; `m0_rsp_o`=1, `m0_rdata_o`=0x1234_5678 in c3.
- **Simultaneous requests:** m0 write (addr 0x20, be 4'b0011, data 0xAABB_CCDD) and m1 read at the same time → m0 granted c0 and `mem_we_o`=1 in c1; m1 granted c2 with `m0_rsp` in c2; `m1_rsp` in c5. A next simultaneous pair goes to m0 first, because the pointer returned to 0 after m1's grant.
- **Out of range:** m1 read at addr 0x4000 (word 4096) → `mem_req_o` stays 0; in c2, `m1_rsp_o`=1, `m1_err_o`=1, `m1_rdata_o`=0xdead_beef.
- **Stall:** `mem_ready_i`=0 for 3 cycles during WR → `mem_req_o` and fields held for 4 cycles; `rsp` in c5.
- **Reset in RD2:** assert `rst_i` during RD2 → `mem_req_o` falls asynchronously; no `rsp`; a re-issued request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD1,
    RD2,
    ERR
  } arb_state_t;

  localparam int unsigned MEM_WORDS = 4096;
  localparam logic [31:0] ERR_DATA  = 32'hdead_beef;

  typedef logic port_id_t;

  // Word index is the byte address with the two low bits dropped.
  function automatic logic word_in_range(input logic [31:0] addr, input int unsigned words);
    return {2'b00, addr[31:2]} < words;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin grant; the pointer names the port that wins a tie.
import mem_arb_pkg::*;

module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  port_id_t ptr_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o        = 2'b00;
      gnt_o[ptr_q] = 1'b1;
    end
  end

  // After any grant the other port gets priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else if (advance_i && (|gnt_o)) begin
      ptr_q <= ~gnt_o[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and two-cycle access sequencer for ext_mem, with registered
// per-port response pulses and out-of-range rejection.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int unsigned MEM_WORDS_P = MEM_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rsp_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rsp_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  arb_state_t  state_q;
  port_id_t    owner_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  rsp_q;
  logic [1:0]  err_q;
  logic [31:0] rdata_q;

  logic [1:0]  arb_gnt;
  logic        in_idle;
  logic        active;
  logic        we_d;
  logic [3:0]  be_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;

  assign in_idle = (state_q == IDLE);

  rr_arb2 u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     ({m1_req_i, m0_req_i}),
    .advance_i (in_idle),
    .gnt_o     (arb_gnt)
  );

  assign m0_gnt_o = in_idle & arb_gnt[0];
  assign m1_gnt_o = in_idle & arb_gnt[1];

  always_comb begin
    we_d    = m0_we_i;
    be_d    = m0_be_i;
    addr_d  = m0_addr_i;
    wdata_d = m0_wdata_i;
    if (arb_gnt[1]) begin
      we_d    = m1_we_i;
      be_d    = m1_be_i;
      addr_d  = m1_addr_i;
      wdata_d = m1_wdata_i;
    end
  end

  // Response pulses default low each cycle so they last exactly one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rsp_q   <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= 32'h0;
    end else begin
      rsp_q <= 2'b00;
      err_q <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (|arb_gnt) begin
            owner_q <= arb_gnt[1];
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (!word_in_range(addr_d, MEM_WORDS_P)) state_q <= ERR;
            else if (we_d)                           state_q <= WR;
            else                                     state_q <= RD1;
          end
        end
        WR: begin
          if (mem_ready_i) begin
            rsp_q[owner_q] <= 1'b1;
            state_q        <= IDLE;
          end
        end
        RD1: begin
          if (mem_ready_i) state_q <= RD2;
        end
        RD2: begin
          if (mem_ready_i) begin
            rdata_q        <= mem_rdata_i;
            rsp_q[owner_q] <= 1'b1;
            state_q        <= IDLE;
          end
        end
        ERR: begin
          rdata_q        <= ERR_DATA;
          rsp_q[owner_q] <= 1'b1;
          err_q[owner_q] <= 1'b1;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from the state register so reset drops them at once.
  assign active      = (state_q == WR) || (state_q == RD1) || (state_q == RD2);
  assign mem_req_o   = active;
  assign mem_we_o    = (state_q == WR);
  assign mem_be_o    = active ? be_q    : 4'h0;
  assign mem_addr_o  = active ? addr_q  : 32'h0;
  assign mem_wdata_o = active ? wdata_q : 32'h0;

  assign m0_rsp_o   = rsp_q[0];
  assign m1_rsp_o   = rsp_q[1];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign m0_rdata_o = rdata_q;
  assign m1_rdata_o = rdata_q;

endmodule
